// File: rtl/io_ir_ctrl.sv
// IR car-remote peripheral: CMD/CTRL/STATUS bus registers, one-deep trigger queue and a shared packet engine.
// IR_LED is registered one cycle behind the engine state; STATUS reads drive BUS_DATA combinationally.
module io_ir_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h90,
  parameter int CMD_BITS   = 4,
  parameter int PERIOD_CYC = 10_000_000,
  parameter int HCYC_B = 1389, HCYC_Y = 1250, HCYC_G = 1333, HCYC_R = 1389,
  parameter int START_B = 191, CARSEL_B = 47, GAP_B = 25, ASSERT_B = 47, DEASSERT_B = 22,
  parameter int START_Y = 88,  CARSEL_Y = 22, GAP_Y = 40, ASSERT_Y = 44, DEASSERT_Y = 22,
  parameter int START_G = 88,  CARSEL_G = 44, GAP_G = 40, ASSERT_G = 44, DEASSERT_G = 22,
  parameter int START_R = 192, CARSEL_R = 24, GAP_R = 24, ASSERT_R = 48, DEASSERT_R = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       IR_LED
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_GAP1, S_CARSEL, S_GAP2, S_BIT, S_GAPB} state_t;
  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int BW = (CMD_BITS > 1) ? $clog2(CMD_BITS) : 1;

  state_t state, state_n;
  logic [3:0] cmd, cartype, pkt_cnt;
  logic periodic_en, pending, overflow;
  logic [PW-1:0] per_cnt;
  logic [CMD_BITS-1:0] cmd_l;
  logic [BW-1:0] bidx;
  logic [15:0] hcyc_l, hcnt, sel_hcyc;
  logic [7:0] start_l, carsel_l, gap_l, asrt_l, deas_l, flen;
  logic [7:0] sel_start, sel_carsel, sel_gap, sel_asrt, sel_deas;
  logic [8:0] pcnt;
  logic wr_cmd, wr_ctrl, rd_stat, fire, per_trig, trig, car_ok;
  logic busy, burst, hc_end, field_end, done, launch;
  logic [7:0] status;

  assign wr_cmd    = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign wr_ctrl   = BUS_WE && (BUS_ADDR == 8'(BASE_ADDR + 8'd1));
  assign rd_stat   = !BUS_WE && (BUS_ADDR == 8'(BASE_ADDR + 8'd2));
  assign fire      = wr_ctrl && BUS_DATA[1];
  assign per_trig  = periodic_en && (per_cnt == PW'(PERIOD_CYC - 1));
  assign car_ok    = $onehot(cartype);
  assign trig      = (fire || per_trig) && car_ok;
  assign busy      = (state != S_IDLE);
  assign burst     = (state == S_START) || (state == S_CARSEL) || (state == S_BIT);
  assign hc_end    = (hcnt == hcyc_l - 16'd1);
  assign field_end = hc_end && (pcnt == {flen, 1'b0} - 9'd1);
  assign done      = (state == S_GAPB) && field_end && (bidx == '0);
  // A queued trigger (or one arriving on the final cycle) restarts the engine with no idle gap.
  assign launch    = (!busy && trig) || (done && car_ok && (pending || trig));

  assign status   = {pkt_cnt, car_ok, overflow, pending, busy};
  assign BUS_DATA = rd_stat ? status : 8'hzz;

  always_comb begin
    sel_hcyc = 16'(HCYC_B); sel_start = 8'(START_B); sel_carsel = 8'(CARSEL_B);
    sel_gap = 8'(GAP_B); sel_asrt = 8'(ASSERT_B); sel_deas = 8'(DEASSERT_B);
    case (cartype)
      4'b0010: begin
        sel_hcyc = 16'(HCYC_Y); sel_start = 8'(START_Y); sel_carsel = 8'(CARSEL_Y);
        sel_gap = 8'(GAP_Y); sel_asrt = 8'(ASSERT_Y); sel_deas = 8'(DEASSERT_Y);
      end
      4'b0100: begin
        sel_hcyc = 16'(HCYC_G); sel_start = 8'(START_G); sel_carsel = 8'(CARSEL_G);
        sel_gap = 8'(GAP_G); sel_asrt = 8'(ASSERT_G); sel_deas = 8'(DEASSERT_G);
      end
      4'b1000: begin
        sel_hcyc = 16'(HCYC_R); sel_start = 8'(START_R); sel_carsel = 8'(CARSEL_R);
        sel_gap = 8'(GAP_R); sel_asrt = 8'(ASSERT_R); sel_deas = 8'(DEASSERT_R);
      end
      default: ;
    endcase
  end

  always_comb begin
    flen = gap_l;
    case (state)
      S_START:  flen = start_l;
      S_CARSEL: flen = carsel_l;
      S_BIT:    flen = cmd_l[bidx] ? asrt_l : deas_l;
      default:  flen = gap_l;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (launch) state_n = S_START;
      S_START:  if (field_end) state_n = S_GAP1;
      S_GAP1:   if (field_end) state_n = S_CARSEL;
      S_CARSEL: if (field_end) state_n = S_GAP2;
      S_GAP2:   if (field_end) state_n = S_BIT;
      S_BIT:    if (field_end) state_n = S_GAPB;
      S_GAPB: begin
        if (field_end) begin
          if (bidx != '0) state_n = S_BIT;
          else            state_n = launch ? S_START : S_IDLE;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd <= '0; cartype <= 4'b0001; periodic_en <= 1'b0; per_cnt <= '0;
      pending <= 1'b0; overflow <= 1'b0; pkt_cnt <= '0;
      cmd_l <= '0; bidx <= '0; hcnt <= '0; pcnt <= '0; hcyc_l <= '0;
      start_l <= '0; carsel_l <= '0; gap_l <= '0; asrt_l <= '0; deas_l <= '0;
      IR_LED <= 1'b0;
    end else begin
      if (wr_cmd) begin
        cmd     <= BUS_DATA[7:4];
        cartype <= BUS_DATA[3:0];
      end
      if (wr_ctrl) periodic_en <= BUS_DATA[0];
      per_cnt <= (!periodic_en || per_trig) ? '0 : per_cnt + PW'(1);

      if (!car_ok)           pending <= 1'b0;
      else if (done)         pending <= pending && trig;
      else if (trig && busy) pending <= 1'b1;

      if (trig && busy && pending && !done) overflow <= 1'b1;
      else if (wr_ctrl && BUS_DATA[7])      overflow <= 1'b0;

      if (done) pkt_cnt <= pkt_cnt + 4'd1;

      if (launch) begin
        cmd_l <= cmd[CMD_BITS-1:0];
        hcyc_l <= sel_hcyc; start_l <= sel_start; carsel_l <= sel_carsel;
        gap_l <= sel_gap; asrt_l <= sel_asrt; deas_l <= sel_deas;
        bidx <= BW'(CMD_BITS - 1);
        hcnt <= '0;
        pcnt <= '0;
      end else if (field_end) begin
        hcnt <= '0;
        pcnt <= '0;
        if (state == S_GAPB) bidx <= bidx - BW'(1);
      end else if (busy) begin
        if (hc_end) begin
          hcnt <= '0;
          pcnt <= pcnt + 9'd1;
        end else begin
          hcnt <= hcnt + 16'd1;
        end
      end

      IR_LED <= burst && !pcnt[0];
    end
  end
endmodule
